// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles.
// Results update with a one-cycle valid strobe; timeout flags a stalled input.
module clk_period_meter #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise;
    logic             sat;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [CNT_W-1:0] per_cnt_nxt, hi_cnt_nxt;
    logic [CNT_W-1:0] period_nxt, high_time_nxt;
    logic             valid_nxt, locked_nxt, timeout_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign sat  = (per_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A rise coinciding with saturation is a valid measurement, not a timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = MEASURE;
            MEASURE: if (!rise && sat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        per_cnt_nxt   = per_cnt;
        hi_cnt_nxt    = hi_cnt;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        locked_nxt    = locked;
        timeout_nxt   = timeout;
        case (state)
            IDLE: begin
                per_cnt_nxt = '0;
                hi_cnt_nxt  = '0;
                if (rise) begin
                    per_cnt_nxt = CNT_ONE;
                    hi_cnt_nxt  = CNT_ONE;
                    timeout_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_nxt    = per_cnt;
                    high_time_nxt = hi_cnt;
                    valid_nxt     = 1'b1;
                    locked_nxt    = 1'b1;
                    per_cnt_nxt   = CNT_ONE;
                    hi_cnt_nxt    = CNT_ONE;
                end else if (sat) begin
                    per_cnt_nxt   = '0;
                    hi_cnt_nxt    = '0;
                    period_nxt    = '0;
                    high_time_nxt = '0;
                    timeout_nxt   = 1'b1;
                    locked_nxt    = 1'b0;
                end else begin
                    per_cnt_nxt = per_cnt + CNT_ONE;
                    if (s2 && hi_cnt != CNT_MAX) hi_cnt_nxt = hi_cnt + CNT_ONE;
                end
            end
            default: begin
                per_cnt_nxt = '0;
                hi_cnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt   <= '0;
            hi_cnt    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            per_cnt   <= per_cnt_nxt;
            hi_cnt    <= hi_cnt_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            valid     <= valid_nxt;
            locked    <= locked_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized scoreboard bench for clk_period_meter with CNT_W = 8.
// Expectations come from rise-to-rise sample indices of the driven waveform.
module tb_clk_period_meter;

    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int LAT   = 2;

    logic             clk;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    clk_period_meter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    typedef struct {
        int          at;
        int unsigned per;
        int unsigned hi;
    } sb_t;

    typedef struct {
        bit          vld;
        bit          lck;
        bit          tmo;
        int unsigned per;
        int unsigned hi;
    } lvl_t;

    sb_t  sb[$];
    lvl_t exp_lvl[int];

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    // reference state: rise indices and high-sample sums over the input samples
    bit          m_armed, m_locked, m_timeout, m_prev;
    int unsigned m_per, m_hi, m_hacc;
    int          m_n0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp_v, n);
        end
    endtask

    always @(posedge clk) begin
        bit   v, r, vld;
        lvl_t l;
        n++;
        if (rst) begin
            m_armed   = 0;
            m_locked  = 0;
            m_timeout = 0;
            m_per     = 0;
            m_hi      = 0;
            m_hacc    = 0;
            m_prev    = 0;
            for (int k = 0; k <= LAT; k++) exp_lvl[n + k] = '{0, 0, 0, 0, 0};
            while (sb.size() > 0 && sb[sb.size() - 1].at >= n) sb.delete(sb.size() - 1);
        end else begin
            v      = sig_in;
            r      = v & ~m_prev;
            m_prev = v;
            vld    = 0;
            if (!m_armed) begin
                if (r) begin
                    m_armed   = 1;
                    m_n0      = n;
                    m_hacc    = 0;
                    m_timeout = 0;
                end
            end else if (r) begin
                m_per    = n - m_n0;
                m_hi     = m_hacc;
                vld      = 1;
                m_locked = 1;
                m_n0     = n;
                m_hacc   = 0;
                sb.push_back('{n + LAT, m_per, m_hi});
            end else if (n - m_n0 == MAXC) begin
                m_armed   = 0;
                m_timeout = 1;
                m_locked  = 0;
                m_per     = 0;
                m_hi      = 0;
            end
            if (m_armed && v) m_hacc++;
            l = '{vld, m_locked, m_timeout, m_per, m_hi};
            exp_lvl[n + LAT] = l;
        end
    end

    always @(negedge clk) begin
        lvl_t e;
        sb_t  it;
        if (exp_lvl.exists(n)) begin
            e = exp_lvl[n];
            exp_lvl.delete(n);
            chk("valid",     32'(valid),     32'(e.vld));
            chk("locked",    32'(locked),    32'(e.lck));
            chk("timeout",   32'(timeout),   32'(e.tmo));
            chk("period",    32'(period),    e.per);
            chk("high_time", 32'(high_time), e.hi);
        end
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 1, 0);
            end else begin
                it = sb.pop_front();
                chk("sb_edge",      n,               it.at);
                chk("sb_period",    32'(period),    it.per);
                chk("sb_high_time", 32'(high_time), it.hi);
            end
        end
    end

    task automatic drive(input logic s, input logic r);
        @(negedge clk);
        sig_in = s;
        rst    = r;
    endtask

    task automatic wave(input int unsigned hi, input int unsigned lo, input int unsigned reps);
        for (int unsigned p = 0; p < reps; p++) begin
            for (int unsigned i = 0; i < hi; i++) drive(1'b1, 1'b0);
            for (int unsigned i = 0; i < lo; i++) drive(1'b0, 1'b0);
        end
    endtask

    initial begin
        int unsigned hi, lo;
        rst    = 1'b1;
        sig_in = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        wave(5, 5, 6);
        wave(3, 7, 5);
        wave(1, 1, 10);
        wave(0, 300, 1);
        wave(5, 5, 3);
        wave(100, 155, 3);
        wave(128, 128, 3);
        wave(5, 5, 3);
        wave(3, 0, 1);
        drive(1'b0, 1'b1);
        wave(0, 1, 1);
        wave(5, 5, 4);
        for (int s = 0; s < 40; s++) begin
            hi = $urandom_range(1, 20);
            lo = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 20);
            if ($urandom_range(0, 19) == 0) begin
                wave(hi, 0, 1);
                drive(1'b0, 1'b1);
            end
            wave(hi, lo, 1);
        end
        wave(0, 8, 1);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
